// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, FSM states and instruction field helpers shared by the parametrised CPU.
package cpu_pkg;
    localparam int IW_MAX = 64;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_NOT  = 4'h5;
    localparam logic [3:0] OP_MUL  = 4'h6;
    localparam logic [3:0] OP_MOV  = 4'h7;
    localparam logic [3:0] OP_MOVI = 4'h8;
    localparam logic [3:0] OP_CMP  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_JZ   = 4'hB;
    localparam logic [3:0] OP_JNZ  = 4'hC;
    localparam logic [3:0] OP_JC   = 4'hD;
    localparam logic [3:0] OP_NOP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_HALT} state_t;

    // Words are zero-extended to IW_MAX so one helper serves every parameter set.
    function automatic logic [3:0] instr_op(input logic [IW_MAX-1:0] ins, input int ra_w, input int opnd_w);
        return 4'(ins >> (ra_w + opnd_w));
    endfunction

    function automatic logic [31:0] instr_rd(input logic [IW_MAX-1:0] ins, input int ra_w, input int opnd_w);
        return 32'((ins >> opnd_w) & ((IW_MAX'(1) << ra_w) - IW_MAX'(1)));
    endfunction

    function automatic logic [31:0] instr_opnd(input logic [IW_MAX-1:0] ins, input int opnd_w);
        return 32'(ins & ((IW_MAX'(1) << opnd_w) - IW_MAX'(1)));
    endfunction
endpackage

// File: rtl/param_regfile.sv
// param_regfile: register file with two asynchronous read ports, one synchronous
// write port and synchronous clear.
module param_regfile #(
    parameter int DATA_W = 8,
    parameter int NREGS = 16,
    localparam int RA_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [RA_W-1:0]   a_addr,
    input  logic [RA_W-1:0]   b_addr,
    input  logic              w_en,
    input  logic [RA_W-1:0]   w_addr,
    input  logic [DATA_W-1:0] w_data,
    output logic [DATA_W-1:0] a_data,
    output logic [DATA_W-1:0] b_data
);
    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk)
        if (reset) regs <= '{default: '0};
        else if (w_en) regs[w_addr] <= w_data;

    assign a_data = regs[a_addr];
    assign b_data = regs[b_addr];
endmodule

// File: rtl/param_cpu_core.sv
// param_cpu_core: multi-cycle FETCH/EXEC CPU with handshaked instruction fetch,
// Zero/Carry flags, conditional branches and HALT.
module param_cpu_core
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NREGS = 16,
    parameter int PC_W = 8,
    parameter int OPND_W = 8,
    localparam int RA_W = $clog2(NREGS),
    localparam int INSTR_W = 4 + RA_W + OPND_W
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_valid,
    output logic [PC_W-1:0]    pc,
    output logic               halted,
    output logic               wb_en,
    output logic [RA_W-1:0]    wb_addr,
    output logic [DATA_W-1:0]  wb_data,
    output logic               flag_z,
    output logic               flag_c
);
    state_t state, state_nx;
    logic [INSTR_W-1:0] ir;
    logic [3:0] op;
    logic [RA_W-1:0] rd, rs;
    logic [OPND_W-1:0] opnd;
    logic [DATA_W-1:0] a, b, res;
    logic cout, arith, logical, writes, taken, z_nx, c_nx;
    logic [PC_W-1:0] pc_nx;

    assign op = instr_op(IW_MAX'(ir), RA_W, OPND_W);
    assign rd = RA_W'(instr_rd(IW_MAX'(ir), RA_W, OPND_W));
    assign opnd = OPND_W'(instr_opnd(IW_MAX'(ir), OPND_W));
    assign rs = RA_W'(opnd);

    param_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_rf (
        .clk(clk), .reset(reset), .a_addr(rd), .b_addr(rs),
        .w_en(wb_en), .w_addr(rd), .w_data(res), .a_data(a), .b_data(b)
    );

    always_comb begin
        cout = 1'b0;
        res = '0;
        case (op)
            OP_ADD:         {cout, res} = {1'b0, a} + {1'b0, b};
            OP_SUB, OP_CMP: begin res = a - b; cout = a < b; end
            OP_AND:         res = a & b;
            OP_OR:          res = a | b;
            OP_XOR:         res = a ^ b;
            OP_NOT:         res = ~a;
            OP_MUL:         res = a * b;
            OP_MOV:         res = b;
            OP_MOVI:        res = DATA_W'(opnd);
            default:        res = '0;
        endcase
    end

    // Branches look at the flags latched by earlier instructions, never at z_nx/c_nx.
    assign arith = op inside {OP_ADD, OP_SUB, OP_CMP};
    assign logical = op inside {OP_AND, OP_OR, OP_XOR, OP_NOT, OP_MUL};
    assign writes = op <= OP_MOVI;
    assign z_nx = (arith || logical) ? res == '0 : flag_z;
    assign c_nx = arith ? cout : flag_c;
    assign taken = op == OP_JMP || (op == OP_JZ && flag_z) || (op == OP_JNZ && !flag_z) || (op == OP_JC && flag_c);
    assign pc_nx = taken ? PC_W'(opnd) : op == OP_HALT ? pc : pc + 1'b1;

    always_ff @(posedge clk)
        if (reset) state <= ST_FETCH;
        else state <= state_nx;

    always_comb
        state_nx = state == ST_FETCH ? (imem_valid ? ST_EXEC : ST_FETCH) :
                   state == ST_EXEC  ? (op == OP_HALT ? ST_HALT : ST_FETCH) : ST_HALT;

    always_comb begin
        imem_req = state == ST_FETCH && !reset;
        halted = state == ST_HALT;
        wb_en = state == ST_EXEC && writes;
        wb_addr = wb_en ? rd : '0;
        wb_data = wb_en ? res : '0;
    end

    always_ff @(posedge clk)
        if (reset) begin
            pc <= '0;
            ir <= {OP_NOP, {(INSTR_W-4){1'b0}}};
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else if (state == ST_FETCH && imem_valid) begin
            ir <= imem_rdata;
        end else if (state == ST_EXEC) begin
            pc <= pc_nx;
            flag_z <= z_nx;
            flag_c <= c_nx;
        end

    assign imem_addr = pc;
endmodule

// File: tb/tb_param_cpu_core.sv
// tb_param_cpu_core: ISA-level reference model feeding a writeback scoreboard, plus a
// cycle timeline of fetch/halt; a second narrow core covers PC wrap and immediate truncation.
module tb_param_cpu_core;
    logic clk = 1'b0, reset = 1'b1, reset2 = 1'b1, force_v = 1'b0;
    always #5 clk = ~clk;

    logic imem_req, imem_valid, halted, wb_en, flag_z, flag_c;
    logic [7:0] imem_addr, pc, wb_data;
    logic [15:0] imem_rdata;
    logic [3:0] wb_addr;

    logic req2, halted2, wb_en2, z2, c2;
    logic [3:0] addr2, pc2, wb_addr2, wb_data2;
    logic [15:0] rdata2;

    param_cpu_core dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid), .pc(pc), .halted(halted),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flag_z(flag_z), .flag_c(flag_c)
    );

    param_cpu_core #(.DATA_W(4), .NREGS(16), .PC_W(4), .OPND_W(8)) dut2 (
        .clk(clk), .reset(reset2), .imem_req(req2), .imem_addr(addr2),
        .imem_rdata(rdata2), .imem_valid(req2), .pc(pc2), .halted(halted2),
        .wb_en(wb_en2), .wb_addr(wb_addr2), .wb_data(wb_data2), .flag_z(z2), .flag_c(c2)
    );

    logic [15:0] prog [256];
    logic [15:0] prog2 [16];
    int lat = 0, wcnt = 0, cyc = 0, rel = 0;

    // Memory answers after `lat` waiting cycles; force_v injects a stray valid.
    assign imem_valid = (imem_req && wcnt >= lat) || force_v;
    assign imem_rdata = prog[imem_addr];
    assign rdata2 = prog2[addr2];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        wcnt <= (imem_req && !imem_valid) ? wcnt + 1 : 0;
    end

    typedef struct {int idx; logic [3:0] a; logic [7:0] d;} wb_t;
    typedef struct {logic [3:0] a; logic [3:0] d;} wb2_t;
    wb_t q[$];
    wb2_t q2[$];
    wb_t e;
    wb2_t e2;
    int checks = 0, errors = 0;
    bit active = 0, exp_h, exp_req, wrapped = 0;
    int idx, n_halt = 0, L = 2, mpc = 0, mz = 0, mc = 0, r3_writes = 0;
    logic [7:0] last_d = '0;
    logic [3:0] pc2_prev = '0;

    function automatic logic [15:0] enc(input int op, input int rd, input int opnd);
        return {4'(op), 4'(rd), 8'(opnd)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Architectural simulation: each instruction costs L = lat + 2 cycles, its write
    // lands in the last cycle of that slot.
    task automatic model_run(input int latency);
        int regs [16];
        int p, z, c, op, rd, opnd, a, b, r;
        foreach (regs[i]) regs[i] = 0;
        p = 0; z = 0; c = 0;
        lat = latency;
        L = latency + 2;
        q.delete();
        for (int n = 0; n < 1000; n++) begin
            op = 32'(prog[p][15:12]);
            rd = 32'(prog[p][11:8]);
            opnd = 32'(prog[p][7:0]);
            a = regs[rd];
            b = regs[opnd % 16];
            case (op)
                0: r = a + b;
                1, 9: r = a - b;
                2: r = a & b;
                3: r = a | b;
                4: r = a ^ b;
                5: r = ~a;
                6: r = a * b;
                7: r = b;
                8: r = opnd;
                default: r = 0;
            endcase
            if (op == 0) c = (r > 255) ? 1 : 0;
            if (op == 1 || op == 9) c = (a < b) ? 1 : 0;
            r = r & 255;
            if (op <= 6 || op == 9) z = (r == 0) ? 1 : 0;
            if (op <= 8) begin
                regs[rd] = r;
                q.push_back('{idx: n * L + L - 1, a: 4'(rd), d: 8'(r)});
            end
            if (op == 15) begin
                n_halt = n + 1;
                break;
            end
            if (op == 10 || (op == 11 && z == 1) || (op == 12 && z == 0) || (op == 13 && c == 1)) p = opnd;
            else p = (p + 1) % 256;
        end
        mpc = p; mz = z; mc = c;
    endtask

    task automatic run(input int latency, input string name);
        reset = 1'b1;
        active = 0;
        repeat (2) @(posedge clk);
        model_run(latency);
        r3_writes = 0;
        #1 reset = 1'b0;
        rel = cyc;
        active = 1;
        repeat (n_halt * L + 12) @(posedge clk);
        #1;
        chk({name, "_pending"}, 32'(q.size()), 0);
        chk({name, "_pc"}, 32'(pc), 32'(mpc));
        chk({name, "_z"}, 32'(flag_z), 32'(mz));
        chk({name, "_c"}, 32'(flag_c), 32'(mc));
        active = 0;
    endtask

    task automatic clear_prog();
        foreach (prog[i]) prog[i] = enc(15, 0, 0);
    endtask

    task automatic gen_random();
        int len, op, opnd;
        clear_prog();
        len = $urandom_range(8, 30);
        for (int i = 0; i < len - 1; i++) begin
            op = (i < 4) ? 8 : $urandom_range(0, 14);
            opnd = $urandom_range(0, 255);
            if (op >= 10 && op <= 13) opnd = $urandom_range(i + 1, len - 1);
            prog[i] = enc(op, $urandom_range(0, 15), opnd);
        end
    endtask

    initial forever begin
        @(negedge clk);
        idx = cyc - rel;
        if (wb_en === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL wb_extra: got R%0d=%h at cycle %0d, required no write", wb_addr, wb_data, idx);
            end else begin
                e = q.pop_front();
                if (wb_addr !== e.a || wb_data !== e.d || idx != e.idx) begin
                    errors++;
                    $display("FAIL wb: got R%0d=%h at cycle %0d, required R%0d=%h at cycle %0d",
                             wb_addr, wb_data, idx, e.a, e.d, e.idx);
                end
            end
            last_d = wb_data;
            if (wb_addr == 4'd3) r3_writes++;
        end
        if (active) begin
            exp_h = idx >= n_halt * L;
            exp_req = !exp_h && (idx % L != L - 1);
            checks++;
            if (imem_req !== exp_req || halted !== exp_h || imem_addr !== pc || (exp_h && pc !== 8'(mpc))) begin
                errors++;
                $display("FAIL timeline cycle %0d: got req=%b halted=%b pc=%0d addr=%0d, required req=%b halted=%b",
                         idx, imem_req, halted, pc, imem_addr, exp_req, exp_h);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!reset2) begin
            if (wb_en2 === 1'b1) begin
                checks++;
                if (q2.size() == 0) begin
                    errors++;
                    $display("FAIL wb2_extra: got R%0d=%h, required no write", wb_addr2, wb_data2);
                end else begin
                    e2 = q2.pop_front();
                    if (wb_addr2 !== e2.a || wb_data2 !== e2.d) begin
                        errors++;
                        $display("FAIL wb2: got R%0d=%h, required R%0d=%h", wb_addr2, wb_data2, e2.a, e2.d);
                    end
                end
            end
            if (pc2_prev == 4'd15 && pc2 == 4'd0) wrapped = 1;
            pc2_prev = pc2;
        end
    end

    initial begin
        // Arithmetic: 0xF0 + 0x20 carries out to 0x10.
        clear_prog();
        prog[0] = enc(8, 1, 'hF0);
        prog[1] = enc(8, 2, 'h20);
        prog[2] = enc(0, 1, 2);
        run(0, "arith");
        chk("arith_result", 32'(last_d), 32'h10);
        chk("arith_flag_c", 32'(flag_c), 1);
        chk("arith_flag_z", 32'(flag_z), 0);

        run(3, "wait3");
        chk("wait3_result", 32'(last_d), 32'h10);

        // Countdown loop: R3 written by MOVI then by SUB three times.
        clear_prog();
        prog[0] = enc(8, 3, 3);
        prog[1] = enc(8, 4, 1);
        prog[2] = enc(1, 3, 4);
        prog[3] = enc(12, 0, 2);
        run(0, "loop");
        chk("loop_r3_writes", 32'(r3_writes), 4);
        chk("loop_pc", 32'(pc), 4);
        chk("loop_flag_z", 32'(flag_z), 1);

        // CMP sets borrow, JC skips the MOVI at 4 and lands on HALT at 9.
        clear_prog();
        prog[0] = enc(8, 1, 1);
        prog[1] = enc(8, 2, 2);
        prog[2] = enc(9, 1, 2);
        prog[3] = enc(13, 0, 9);
        prog[4] = enc(8, 6, 'h77);
        run(0, "jc");
        chk("jc_pc", 32'(pc), 9);
        chk("jc_flag_c", 32'(flag_c), 1);

        // Reset arriving together with a valid word mid-fetch.
        clear_prog();
        prog[0] = enc(7, 4, 1);
        prog[1] = enc(0, 5, 2);
        lat = 3;
        q.delete();
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        force_v = 1'b1;
        @(posedge clk);
        #1 force_v = 1'b0;
        chk("rst_fetch_pc", 32'(pc), 0);
        chk("rst_fetch_req", 32'(imem_req), 0);
        chk("rst_fetch_wb", 32'(wb_en), 0);
        @(posedge clk);
        #1 chk("rst_fetch_wb_next", 32'(wb_en), 0);
        run(3, "after_rst");

        for (int k = 0; k < 6; k++) begin
            gen_random();
            run($urandom_range(0, 2), "rand");
        end

        // Narrow core: NOP at 15 wraps to 0; second JZ at 0 is taken; 0xAB truncates to 0xB.
        foreach (prog2[i]) prog2[i] = enc(15, 0, 0);
        prog2[0] = enc(11, 0, 3);
        prog2[1] = enc(10, 0, 14);
        prog2[2] = enc(14, 0, 0);
        prog2[3] = enc(8, 5, 'hAB);
        prog2[14] = enc(4, 0, 0);
        prog2[15] = enc(14, 0, 0);
        q2.push_back('{a: 4'd0, d: 4'h0});
        q2.push_back('{a: 4'd5, d: 4'hB});
        @(posedge clk);
        #1 reset2 = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        chk("wrap_seen", 32'(wrapped), 1);
        chk("wrap_pending", 32'(q2.size()), 0);
        chk("wrap_halted", 32'(halted2), 1);
        chk("wrap_pc", 32'(pc2), 4);
        chk("wrap_flag_z", 32'(z2), 1);
        chk("wrap_req", 32'(req2), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
